cvt_i_fp_mod: RTL and testbench
===============================

Name: cvt_i_fp_mod

Overview:
- Pipelined integer-to-floating-point converter; the inverse of the FP-to-integer converter on the u5 FPU lane.
- Takes a 32- or 64-bit signed or unsigned integer from the integer datapath.
- Produces a single, double or extended (x87 80-bit) result for the FUF forwarding/writeback path.
- Latency is 3 clock-enabled cycles, one op accepted per enabled cycle. An op tag travels with each result.

Parameters:
- TAG_W, 6, width of the opaque op tag carried from input to result (FU/register id).
- RND_DEFAULT, 0, rounding mode used when rmode is 4..7.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- clkEn  input  1  pipeline advance enable; 0 freezes every stage
- en  input  1  op valid at stage 0; sampled only when clkEn=1
- A  input  64  integer operand
- is32b  input  1  use A[31:0] only; sign-extend if signed, zero-extend if unsigned
- isUns  input  1  treat operand as unsigned
- isSNG  input  1  target single
- isDBL  input  1  target double
- isEXT  input  1  target extended; exactly one of isSNG/isDBL/isEXT set when en=1
- rmode  input  3  0 RNE, 1 RZ, 2 toward -inf, 3 toward +inf
- tag_in  input  TAG_W  op tag
- res  output  64  single in [31:0] with [63:32]=0; double in [63:0]; extended significand (explicit integer bit) in [63:0]
- res_hi  output  16  extended {sign, exp15}; 0 for single/double
- inexact  output  1  rounding discarded nonzero bits
- vld  output  1  res/res_hi/inexact/tag_out valid this cycle
- tag_out  output  TAG_W  tag of the op in res

Behaviour:
- Reset: rst=1 at a posedge clears all stage valids and sets res, res_hi, inexact, vld, tag_out to 0. rst has priority over clkEn.
- Stage 1 (on clkEn):
  - latch en, fmt, rmode and tag.
  - Select operand per is32b/isUns.
  - Compute sign = signed & operand[63], and mag = |operand| as 64-bit unsigned. -2^63 gives mag 0x8000000000000000.
- Stage 2:
  - 64-bit leading-zero count.
  - Left-normalize mag so bit 63 = 1.
  - Unbiased exponent e = 63 - lzc.
  - zero flag = (mag==0).
- Stage 3:
  - Round to 24 (SNG) or 53 (DBL) significant bits using guard bit and OR-of-rest sticky.
  - RNE: increment if guard & (sticky | lsb).
  - RZ: never increment.
  - toward -inf: increment if sign & (guard|sticky).
  - toward +inf: increment if ~sign & (guard|sticky).
  - Mantissa carry-out: set mantissa to 1.0 and increment e.
  - Pack with bias 127, 1023 or 16383.
  - EXT is always exact: 64-bit significand, no rounding.
  - No overflow is possible (max e=64).
- Zero input: +0.0 in the target format, inexact=0, res_hi=0, sign=0 for both signed and unsigned zero.
- inexact = guard|sticky for SNG/DBL; always 0 for EXT.
- Latency: an op with en=1 at enabled edge N appears with vld=1 after enabled edge N+2, i.e. three enabled edges including N. Disabled cycles do not count.
- clkEn=0: all stage registers and outputs hold. vld stays asserted if it was set, so the same result is presented again. A downstream consumer samples only when clkEn=1.
- Bubbles (en=0) propagate as vld=0. The outputs of a bubble stage are don't-care but are driven to 0.
- Back-to-back ops: full throughput, one op per enabled cycle, results in order.
- Reset mid-operation: every in-flight op is discarded. No vld is produced for ops accepted before the reset edge.
- Illegal fmt (not exactly one-hot): result undefined, vld still produced, no hang.

Test Plan:
- 64-bit signed A=1, isDBL, RNE, 3 enabled cycles -> vld=1, res=0x3FF0000000000000, inexact=0; A=0xFFFFFFFFFFFFFFFF signed, isSNG -> res=0x00000000BF800000.
- 32-bit signed A=0x0000000001000001 (2^24+1), isSNG: RNE -> res=0x4B800000, inexact=1; rmode=3 -> res=0x4B800001, inexact=1; rmode=1 -> 0x4B800000.
- Boundaries:
  - unsigned A=0xFFFFFFFFFFFFFFFF, isDBL, RNE -> 0x43F0000000000000 (carry into exponent), inexact=1.
  - signed A=0x8000000000000000, isDBL -> 0xC3E0000000000000, inexact=0.
  - isEXT with the same A -> res_hi=0xC03E, res=0x8000000000000000.
- A=0 signed and unsigned, each format -> res=0, res_hi=0, inexact=0, vld=1.
- Stream 4 ops back-to-back with tags 1..4, clkEn=0 for 2 cycles mid-stream -> outputs hold during stall; results emerge in tag order 1..4 with no loss or duplicate enabled-cycle valids.
- rst asserted 1 cycle after 2 ops were accepted -> vld=0 and all outputs 0 next cycle; no stale results appear afterwards; a new op after reset completes normally in 3 cycles.

Source files
------------

// File: rtl/cvt_i_fp_mod.sv
// cvt_i_fp_mod: 3-stage pipelined 32/64-bit signed/unsigned integer to single/double/extended converter
module cvt_i_fp_mod #(
  parameter int TAG_W = 6,
  parameter int RND_DEFAULT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             en,
  input  logic [63:0]      A,
  input  logic             is32b,
  input  logic             isUns,
  input  logic             isSNG,
  input  logic             isDBL,
  input  logic             isEXT,
  input  logic [2:0]       rmode,
  input  logic [TAG_W-1:0] tag_in,
  output logic [63:0]      res,
  output logic [15:0]      res_hi,
  output logic             inexact,
  output logic             vld,
  output logic [TAG_W-1:0] tag_out
);
  logic [63:0] op;
  logic sg0;
  logic v1, s1;
  logic [2:0] f1;
  logic [1:0] rm1;
  logic [TAG_W-1:0] t1;
  logic [63:0] m1;
  assign op = is32b ? (isUns ? {32'b0, A[31:0]} : {{32{A[31]}}, A[31:0]}) : A;
  assign sg0 = ~isUns & op[63];
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (clkEn) begin
      v1 <= en;
      f1 <= {isEXT, isDBL, isSNG};
      rm1 <= rmode[2] ? 2'(RND_DEFAULT) : rmode[1:0];
      t1 <= tag_in;
      s1 <= sg0;
      m1 <= sg0 ? -op : op;
    end
  end
  logic [5:0] msb;
  logic [63:0] norm;
  logic v2, s2, z2;
  logic [2:0] f2;
  logic [1:0] rm2;
  logic [TAG_W-1:0] t2;
  logic [63:0] n2;
  logic [5:0] e2;
  always_comb begin
    msb = '0;
    for (int i = 0; i < 64; i++) msb = m1[i] ? 6'(i) : msb;
  end
  assign norm = m1 << (6'd63 - msb);
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (clkEn) begin
      v2 <= v1;
      f2 <= f1;
      rm2 <= rm1;
      t2 <= t1;
      s2 <= s1;
      n2 <= norm;
      e2 <= msb;
      z2 <= m1 == 64'd0;
    end
  end
  // The hidden bit is always 1, so a carry out of the fraction add means the mantissa wrapped to 1.0
  function automatic logic rnd(input logic [1:0] m, input logic sg, g, st, l);
    return m == 2'd0 ? g & (st | l) : m == 2'd1 ? 1'b0 : m == 2'd2 ? sg & (g | st) : ~sg & (g | st);
  endfunction
  logic inc_s, inc_d, cs, cd, ix, live;
  logic [22:0] fs;
  logic [51:0] fd;
  logic [7:0] es;
  logic [10:0] ed;
  logic [14:0] ex;
  logic [63:0] r;
  logic [15:0] rh;
  assign inc_s = rnd(rm2, s2, n2[39], |n2[38:0], n2[40]);
  assign inc_d = rnd(rm2, s2, n2[10], |n2[9:0], n2[11]);
  assign {cs, fs} = {1'b0, n2[62:40]} + 24'(inc_s);
  assign {cd, fd} = {1'b0, n2[62:11]} + 53'(inc_d);
  assign es = 8'(e2) + 8'(cs) + 8'd127;
  assign ed = 11'(e2) + 11'(cd) + 11'd1023;
  assign ex = 15'(e2) + 15'd16383;
  assign r = f2[0] ? {32'b0, s2, es, fs} : f2[1] ? {s2, ed, fd} : n2;
  assign rh = f2[2] ? {s2, ex} : 16'b0;
  assign ix = f2[0] ? n2[39] | (|n2[38:0]) : f2[1] ? n2[10] | (|n2[9:0]) : 1'b0;
  assign live = v2 & ~z2;
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      res <= '0;
      res_hi <= '0;
      inexact <= 1'b0;
      tag_out <= '0;
    end else if (clkEn) begin
      vld <= v2;
      res <= live ? r : '0;
      res_hi <= live ? rh : '0;
      inexact <= live & ix;
      tag_out <= v2 ? t2 : '0;
    end
  end
endmodule

// File: tb/tb_cvt_i_fp_mod.sv
// tb_cvt_i_fp_mod: randomized and directed checks of cvt_i_fp_mod against an arithmetic reference model
module tb_cvt_i_fp_mod;
  logic clk = 1'b0;
  logic rst = 1'b0, clkEn = 1'b0, en = 1'b0;
  logic [63:0] A = '0;
  logic is32b = 1'b0, isUns = 1'b0, isSNG = 1'b0, isDBL = 1'b0, isEXT = 1'b0;
  logic [2:0] rmode = '0;
  logic [5:0] tag_in = '0, tag_out;
  logic [63:0] res;
  logic [15:0] res_hi;
  logic inexact, vld;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  cvt_i_fp_mod dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .en(en), .A(A), .is32b(is32b), .isUns(isUns),
    .isSNG(isSNG), .isDBL(isDBL), .isEXT(isEXT), .rmode(rmode), .tag_in(tag_in),
    .res(res), .res_hi(res_hi), .inexact(inexact), .vld(vld), .tag_out(tag_out)
  );

  typedef struct packed {
    logic v;
    logic [5:0] tag;
    logic [63:0] res;
    logic [15:0] hi;
    logic ix;
  } ent_t;

  typedef struct {
    logic [63:0] a;
    bit w, u;
    int f, rm;
    logic [63:0] r;
    logic [15:0] h;
    bit x;
  } dvec_t;

  // Rounds by comparing the discarded remainder against one half ulp
  function automatic ent_t model(input logic [63:0] a, input bit w, u, input int f, rm, input logic [5:0] tg);
    ent_t r;
    logic [63:0] v, mag, q, rem, half, frac;
    bit sg, up;
    int msb, p, sh, e, m;
    r = '0;
    r.v = 1'b1;
    r.tag = tg;
    v = w ? (u ? {32'b0, a[31:0]} : {{32{a[31]}}, a[31:0]}) : a;
    sg = !u && v[63];
    mag = sg ? -v : v;
    if (mag == 64'd0) return r;
    msb = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) msb = i;
    m = rm > 3 ? 0 : rm;
    if (f == 2) begin
      r.hi = {sg, 15'(msb + 16383)};
      r.res = mag << (63 - msb);
      return r;
    end
    p = f == 0 ? 24 : 53;
    sh = msb - p + 1;
    if (sh <= 0) begin
      q = mag << (-sh);
      rem = '0;
      half = '0;
    end else begin
      q = mag >> sh;
      rem = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
    end
    r.ix = rem != 64'd0;
    up = m == 0 ? (rem > half || (rem == half && rem != 64'd0 && q[0])) :
         m == 1 ? 1'b0 : m == 2 ? (sg && rem != 64'd0) : (!sg && rem != 64'd0);
    q = q + 64'(up);
    e = msb;
    if (q == (64'd1 << p)) begin
      q = q >> 1;
      e++;
    end
    frac = q - (64'd1 << (p - 1));
    r.res = f == 0 ? {32'b0, sg, 8'(e + 127), frac[22:0]} : {sg, 11'(e + 1023), frac[51:0]};
    return r;
  endfunction

  task automatic drive(input logic [63:0] a, input bit w, u, input int f, rm, input logic [5:0] tg);
    A = a;
    is32b = w;
    isUns = u;
    isSNG = f == 0;
    isDBL = f == 1;
    isEXT = f == 2;
    rmode = 3'(rm);
    tag_in = tg;
  endtask

  task automatic run_op(input logic [63:0] a, input bit w, u, input int f, rm, input logic [5:0] tg);
    drive(a, w, u, f, rm, tg);
    clkEn = 1'b1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clkEn = 1'b0;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({vld, tag_out, res, res_hi, inexact} !== 88'd0) begin
      errors++;
      $display("FAIL reset: got vld=%b tag=%h res=%h hi=%h ix=%b, expected all zero", vld, tag_out, res, res_hi, inexact);
    end
    rst = 1'b0;
    clkEn = 1'b1;
  endtask

  task automatic test_directed();
    dvec_t dv[12];
    ent_t exp;
    dv[0]  = '{64'h1, 1'b0, 1'b0, 1, 0, 64'h3FF0000000000000, 16'h0, 1'b0};
    dv[1]  = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 0, 0, 64'h00000000BF800000, 16'h0, 1'b0};
    dv[2]  = '{64'h0000000001000001, 1'b1, 1'b0, 0, 0, 64'h4B800000, 16'h0, 1'b1};
    dv[3]  = '{64'h0000000001000001, 1'b1, 1'b0, 0, 3, 64'h4B800001, 16'h0, 1'b1};
    dv[4]  = '{64'h0000000001000001, 1'b1, 1'b0, 0, 1, 64'h4B800000, 16'h0, 1'b1};
    dv[5]  = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 1, 0, 64'h43F0000000000000, 16'h0, 1'b1};
    dv[6]  = '{64'h8000000000000000, 1'b0, 1'b0, 1, 0, 64'hC3E0000000000000, 16'h0, 1'b0};
    dv[7]  = '{64'h8000000000000000, 1'b0, 1'b0, 2, 0, 64'h8000000000000000, 16'hC03E, 1'b0};
    dv[8]  = '{64'h0000000001000001, 1'b1, 1'b0, 0, 5, 64'h4B800000, 16'h0, 1'b1};
    dv[9]  = '{64'hFFFFFFFFFEFFFFFF, 1'b1, 1'b0, 0, 2, 64'hCB800001, 16'h0, 1'b1};
    dv[10] = '{64'h0000000080000000, 1'b1, 1'b1, 1, 0, 64'h41E0000000000000, 16'h0, 1'b0};
    dv[11] = '{64'h0000000080000000, 1'b1, 1'b0, 1, 0, 64'hC1E0000000000000, 16'h0, 1'b0};
    foreach (dv[i]) begin
      run_op(dv[i].a, dv[i].w, dv[i].u, dv[i].f, dv[i].rm, 6'(i + 8));
      exp = {1'b1, 6'(i + 8), dv[i].r, dv[i].h, dv[i].x};
      vectors++;
      if ({vld, tag_out, res, res_hi, inexact} !== exp) begin
        errors++;
        $display("FAIL directed[%0d]: got vld=%b tag=%h res=%h hi=%h ix=%b, expected vld=1 tag=%h res=%h hi=%h ix=%b",
                 i, vld, tag_out, res, res_hi, inexact, exp.tag, exp.res, exp.hi, exp.ix);
      end
    end
  endtask

  task automatic test_zero();
    logic [63:0] a;
    for (int u = 0; u < 2; u++)
      for (int f = 0; f < 3; f++)
        for (int w = 0; w < 2; w++) begin
          a = w != 0 ? 64'hDEADBEEF00000000 : 64'd0;
          run_op(a, w != 0, u != 0, f, 0, 6'(u * 6 + f * 2 + w));
          vectors++;
          if ({vld, tag_out, res, res_hi, inexact} !== {1'b1, 6'(u * 6 + f * 2 + w), 81'd0}) begin
            errors++;
            $display("FAIL zero u=%0d f=%0d w=%0d: got vld=%b tag=%h res=%h hi=%h ix=%b, expected vld=1 and zero result",
                     u, f, w, vld, tag_out, res, res_hi, inexact);
          end
        end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t exp, nxt;
    logic [63:0] a;
    bit ce, e, w, u;
    int f, rm;
    logic [5:0] tg;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q = {ent_t'(0), ent_t'(0)};
    exp = '0;
    for (int c = 0; c < 400; c++) begin
      ce = $urandom_range(0, 4) != 0;
      e = $urandom_range(0, 3) != 0;
      a = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) a = '0;
      w = $urandom_range(0, 1) != 0;
      u = $urandom_range(0, 1) != 0;
      f = $urandom_range(0, 2);
      rm = $urandom_range(0, 7);
      tg = 6'($urandom());
      drive(a, w, u, f, rm, tg);
      clkEn = ce;
      en = e;
      nxt = e ? model(a, w, u, f, rm, tg) : '0;
      @(negedge clk);
      if (ce) begin
        q.push_back(nxt);
        exp = q.pop_front();
      end
      vectors++;
      if ({vld, tag_out, res, res_hi, inexact} !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got vld=%b tag=%h res=%h hi=%h ix=%b, expected vld=%b tag=%h res=%h hi=%h ix=%b",
                 c, vld, tag_out, res, res_hi, inexact, exp.v, exp.tag, exp.res, exp.hi, exp.ix);
      end
    end
    clkEn = 1'b1;
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] oa[4];
    int of[4];
    ent_t cur, prev, exp;
    int k, got;
    bit ce;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      oa[i] = {$urandom(), $urandom()};
      of[i] = $urandom_range(0, 2);
    end
    k = 0;
    got = 0;
    prev = {vld, tag_out, res, res_hi, inexact};
    for (int c = 0; c < 12; c++) begin
      ce = !(c == 3 || c == 4);
      clkEn = ce;
      if (k < 4) drive(oa[k], 1'b0, 1'b0, of[k], 0, 6'(k + 1));
      en = k < 4;
      @(negedge clk);
      if (ce && k < 4) k++;
      cur = {vld, tag_out, res, res_hi, inexact};
      if (!ce) begin
        vectors++;
        if (cur !== prev) begin
          errors++;
          $display("FAIL stall_hold[%0d]: got vld=%b tag=%h res=%h, expected held vld=%b tag=%h res=%h",
                   c, cur.v, cur.tag, cur.res, prev.v, prev.tag, prev.res);
        end
      end else if (vld) begin
        exp = got < 4 ? model(oa[got], 1'b0, 1'b0, of[got], 0, 6'(got + 1)) : '0;
        vectors++;
        if (got >= 4 || cur !== exp) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got tag=%h res=%h hi=%h ix=%b, expected tag=%h res=%h hi=%h ix=%b",
                   c, cur.tag, cur.res, cur.hi, cur.ix, exp.tag, exp.res, exp.hi, exp.ix);
        end
        got++;
      end
      prev = cur;
    end
    vectors++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d valid results, expected 4", got);
    end
    clkEn = 1'b1;
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    ent_t exp;
    clkEn = 1'b1;
    drive(64'd5, 1'b0, 1'b0, 1, 0, 6'd33);
    en = 1'b1;
    @(negedge clk);
    drive(64'd7, 1'b0, 1'b0, 0, 0, 6'd34);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({vld, tag_out, res, res_hi, inexact} !== 88'd0) begin
      errors++;
      $display("FAIL reset_mid: got vld=%b tag=%h res=%h hi=%h ix=%b, expected all zero", vld, tag_out, res, res_hi, inexact);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (vld !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale[%0d]: got vld=%b tag=%h, expected vld=0", c, vld, tag_out);
      end
    end
    run_op(64'd3, 1'b0, 1'b0, 0, 0, 6'd35);
    exp = model(64'd3, 1'b0, 1'b0, 0, 0, 6'd35);
    vectors++;
    if ({vld, tag_out, res, res_hi, inexact} !== exp) begin
      errors++;
      $display("FAIL reset_recover: got vld=%b tag=%h res=%h ix=%b, expected vld=1 tag=%h res=%h ix=%b",
               vld, tag_out, res, inexact, exp.tag, exp.res, exp.ix);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_zero();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
